// File: rtl/trace_request_queue.sv
// Timestamped trace request queue: buffers requests in order and releases the head once the
// free-running cycle counter reaches its timestamp. Flags out-of-order and reserved-op input.
module trace_request_queue #(
    parameter int unsigned ADDRESS_WIDTH = 33,
    parameter int unsigned TIME_WIDTH    = 32,
    parameter int unsigned DEPTH         = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [TIME_WIDTH-1:0]      in_time,
    input  logic [1:0]                 in_op,
    input  logic [ADDRESS_WIDTH-1:0]   in_addr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 out_op,
    output logic [ADDRESS_WIDTH-1:0]   out_addr,
    output logic [TIME_WIDTH-1:0]      out_time,
    output logic                       out_late,
    output logic [TIME_WIDTH-1:0]      cycle_count,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       order_err,
    output logic                       op_err
);

    localparam int unsigned PtrWidth   = $clog2(DEPTH);
    localparam int unsigned CntWidth   = PtrWidth + 1;
    localparam logic [1:0]  OpReserved = 2'd3;

    logic [TIME_WIDTH-1:0]    time_mem [DEPTH];
    logic [1:0]               op_mem   [DEPTH];
    logic [ADDRESS_WIDTH-1:0] addr_mem [DEPTH];

    logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0]   count_q, count_d;
    logic [TIME_WIDTH-1:0] cycle_q, cycle_d;
    logic [TIME_WIDTH-1:0] last_time_q, last_time_d;
    logic                  order_err_q, order_err_d;
    logic                  op_err_q, op_err_d;

    logic accept;
    logic store;
    logic pop;

    assign accept = in_valid && in_ready;
    assign store  = accept && (in_op != OpReserved);
    assign pop    = out_valid && out_ready;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        cycle_d     = cycle_q;
        last_time_d = last_time_q;
        order_err_d = order_err_q;
        op_err_d    = op_err_q;

        if (store) begin
            wr_ptr_d    = wr_ptr_q + PtrWidth'(1);
            last_time_d = in_time;
            if (in_time < last_time_q) begin
                order_err_d = 1'b1;
            end
        end
        if (accept && !store) begin
            op_err_d = 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrWidth'(1);
        end

        unique case ({store, pop})
            2'b10:   count_d = count_q + CntWidth'(1);
            2'b01:   count_d = count_q - CntWidth'(1);
            default: count_d = count_q;
        endcase

        // Saturate instead of wrapping so a timestamp is never mistaken as due again.
        if (cycle_q != '1) begin
            cycle_d = cycle_q + TIME_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cycle_q     <= '0;
            last_time_q <= '0;
            order_err_q <= 1'b0;
            op_err_q    <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cycle_q     <= cycle_d;
            last_time_q <= last_time_d;
            order_err_q <= order_err_d;
            op_err_q    <= op_err_d;
        end
    end

    // Payload storage carries no reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (store) begin
            time_mem[wr_ptr_q] <= in_time;
            op_mem[wr_ptr_q]   <= in_op;
            addr_mem[wr_ptr_q] <= in_addr;
        end
    end

    assign out_time    = time_mem[rd_ptr_q];
    assign out_op      = op_mem[rd_ptr_q];
    assign out_addr    = addr_mem[rd_ptr_q];
    assign full        = (count_q == CntWidth'(DEPTH));
    assign empty       = (count_q == '0);
    assign in_ready    = !full;
    assign out_valid   = !empty && (cycle_q >= out_time);
    assign out_late    = out_valid && (cycle_q > out_time);
    assign cycle_count = cycle_q;
    assign count       = count_q;
    assign order_err   = order_err_q;
    assign op_err      = op_err_q;

endmodule
